// File: rtl/csr_perf_unit_if.sv
// csr_perf_unit_if: CSR access bus between the EX stage (master) and csr_perf_unit (slave)
//   csr_valid    - CSR instruction present in EX
//   stall        - EX held; suppresses the write
//   csr_addr     - 12-bit CSR address
//   csr_func3    - instruction funct3
//   csr_rs1_data - forwarded rs1 value
//   csr_zimm     - rs1 field / zero-extended immediate
//   csr_rdata    - old CSR value, combinational
//   csr_illegal  - access is illegal, combinational
interface csr_perf_unit_if #(parameter int XLEN = 32);
  logic            csr_valid;
  logic            stall;
  logic [11:0]     csr_addr;
  logic [2:0]      csr_func3;
  logic [XLEN-1:0] csr_rs1_data;
  logic [4:0]      csr_zimm;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;
  modport master (output csr_valid, stall, csr_addr, csr_func3, csr_rs1_data, csr_zimm,
                  input  csr_rdata, csr_illegal);
  modport slave  (input  csr_valid, stall, csr_addr, csr_func3, csr_rs1_data, csr_zimm,
                  output csr_rdata, csr_illegal);
endinterface

// File: rtl/csr_perf_unit.sv
// csr_perf_unit: CSR file with scratch registers, cycle/instret/event counters and count inhibit
//   clk, rst_n   - clock, asynchronous active-low reset
//   bus          - csr_perf_unit_if.slave CSR access bus (reads combinational, writes registered)
//   retire_i     - one instruction retired this cycle
//   hpm_event_i  - per-counter event strobes
//   Define CSR_HPM_EN to implement the event counters and their inhibit bits.
module csr_perf_unit #(
  parameter int XLEN        = 32,
  parameter int CNT_W       = 64,
  parameter int NUM_SCRATCH = 4,
  parameter int NUM_HPM     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  csr_perf_unit_if.slave      bus,
  input  logic                retire_i,
  input  logic [NUM_HPM-1:0]  hpm_event_i
);
  logic [11:0]       a;
  logic [4:0]        idx;
  logic [XLEN-1:0]   src, old, wdata, inh_rd, msc_q, msc_d;
  logic [XLEN-1:0]   scr_q [NUM_SCRATCH];
  logic [XLEN-1:0]   scr_d [NUM_SCRATCH];
  logic [CNT_W-1:0]  cyc_q, cyc_d, ins_q, ins_d, hpm_val, cnt_val;
  logic [2*XLEN-1:0] cnt_ext;
  logic              wen, op_ok, hpm_hit, is_cnt, mapped, illegal, commit, cnt_wr;
  logic              cy_inh_q, cy_inh_d, ir_inh_q, ir_inh_d;
`ifdef CSR_HPM_EN
  logic [CNT_W-1:0]   hpm_q [NUM_HPM];
  logic [CNT_W-1:0]   hpm_d [NUM_HPM];
  logic [NUM_HPM-1:0] hpm_inh_q, hpm_inh_d;
`else
  logic unused_hpm;
  assign unused_hpm = ^hpm_event_i;
`endif
  // A counter write replaces one XLEN half; otherwise one CNT_W-bit add so carries ripple into the high half.
  function automatic logic [CNT_W-1:0] cnt_upd(input logic [CNT_W-1:0] v, input logic wr,
                                               input logic hi, input logic [XLEN-1:0] wd, input logic inc);
    logic [2*XLEN-1:0] ve;
    ve = (2*XLEN)'(v);
    return wr ? CNT_W'(hi ? {wd, ve[XLEN-1:0]} : {ve[2*XLEN-1:XLEN], wd}) : v + CNT_W'(inc);
  endfunction
  assign a       = bus.csr_addr;
  assign idx     = a[4:0];
  assign src     = bus.csr_func3[2] ? XLEN'(bus.csr_zimm) : bus.csr_rs1_data;
  // Set/clear forms with a zero rs1 field are pure reads.
  assign wen     = bus.csr_func3[1:0] == 2'b01 || bus.csr_zimm != 5'd0;
  assign op_ok   = bus.csr_func3[1:0] != 2'b00;
  assign hpm_hit = idx >= 5'd3 && idx < 5'(3 + NUM_HPM);
  assign is_cnt  = (a[11:8] == 4'hB || a[11:8] == 4'hC) && a[6:5] == 2'b00 &&
                   (idx == 5'd0 || idx == 5'd2 || hpm_hit);
`ifdef CSR_HPM_EN
  assign inh_rd  = XLEN'({hpm_inh_q, ir_inh_q, 1'b0, cy_inh_q});
`else
  assign inh_rd  = XLEN'({ir_inh_q, 1'b0, cy_inh_q});
`endif
  always_comb begin
    hpm_val = '0;
`ifdef CSR_HPM_EN
    for (int i = 0; i < NUM_HPM; i++) hpm_val = idx == 5'(3 + i) ? hpm_q[i] : hpm_val;
`endif
  end
  assign cnt_val = idx == 5'd0 ? cyc_q : idx == 5'd2 ? ins_q : hpm_val;
  assign cnt_ext = (2*XLEN)'(cnt_val);
  always_comb begin
    old    = '0;
    mapped = 1'b0;
    if (a == 12'h320) begin
      mapped = 1'b1;
      old    = inh_rd;
    end
    if (a == 12'h340) begin
      mapped = 1'b1;
      old    = msc_q;
    end
    for (int k = 0; k < NUM_SCRATCH; k++)
      if (a == 12'(12'h7C0 + k)) begin
        mapped = 1'b1;
        old    = scr_q[k];
      end
    if (is_cnt) begin
      mapped = 1'b1;
      old    = a[7] ? cnt_ext[2*XLEN-1:XLEN] : cnt_ext[XLEN-1:0];
    end
  end
  assign illegal         = bus.csr_valid && (!mapped || !op_ok || (a[11:10] == 2'b11 && wen));
  assign bus.csr_illegal = illegal;
  assign bus.csr_rdata   = bus.csr_valid && !illegal ? old : '0;
  assign commit          = bus.csr_valid && !bus.stall && !illegal && wen;
  assign cnt_wr          = commit && a[11:8] == 4'hB;
  assign wdata           = bus.csr_func3[1:0] == 2'b01 ? src :
                           bus.csr_func3[1:0] == 2'b10 ? old | src : old & ~src;
  always_comb begin
    msc_d    = commit && a == 12'h340 ? wdata : msc_q;
    for (int k = 0; k < NUM_SCRATCH; k++) scr_d[k] = commit && a == 12'(12'h7C0 + k) ? wdata : scr_q[k];
    cy_inh_d = commit && a == 12'h320 ? wdata[0] : cy_inh_q;
    ir_inh_d = commit && a == 12'h320 ? wdata[2] : ir_inh_q;
    cyc_d    = cnt_upd(cyc_q, cnt_wr && idx == 5'd0, a[7], wdata, !cy_inh_q);
    ins_d    = cnt_upd(ins_q, cnt_wr && idx == 5'd2, a[7], wdata, retire_i && !ir_inh_q);
`ifdef CSR_HPM_EN
    for (int i = 0; i < NUM_HPM; i++) begin
      hpm_inh_d[i] = commit && a == 12'h320 ? wdata[3+i] : hpm_inh_q[i];
      hpm_d[i]     = cnt_upd(hpm_q[i], cnt_wr && idx == 5'(3 + i), a[7], wdata,
                             hpm_event_i[i] && !hpm_inh_q[i]);
    end
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      msc_q    <= '0;
      scr_q    <= '{default: '0};
      cy_inh_q <= 1'b0;
      ir_inh_q <= 1'b0;
      cyc_q    <= '0;
      ins_q    <= '0;
`ifdef CSR_HPM_EN
      hpm_inh_q <= '0;
      hpm_q     <= '{default: '0};
`endif
    end else begin
      msc_q    <= msc_d;
      scr_q    <= scr_d;
      cy_inh_q <= cy_inh_d;
      ir_inh_q <= ir_inh_d;
      cyc_q    <= cyc_d;
      ins_q    <= ins_d;
`ifdef CSR_HPM_EN
      hpm_inh_q <= hpm_inh_d;
      hpm_q     <= hpm_d;
`endif
    end
endmodule

// File: tb/tb_csr_perf_unit.sv
// tb_csr_perf_unit: scoreboard bench for csr_perf_unit
module tb_csr_perf_unit;
  localparam logic [2:0] RW = 3'b001, RS = 3'b010, RC = 3'b011, RWI = 3'b101, RSI = 3'b110, RCI = 3'b111;
`ifdef CSR_HPM_EN
  localparam bit HPM = 1'b1;
`else
  localparam bit HPM = 1'b0;
`endif
  localparam logic [31:0] INH_ALL = HPM ? 32'h7D : 32'h5;
  localparam logic [31:0] HPM7    = HPM ? 32'h7 : 32'h0;
  localparam logic [31:0] HPM10   = HPM ? 32'h10 : 32'h0;
  logic clk = 1'b0, rst_n = 1'b0, retire = 1'b0;
  logic [3:0] ev = 4'h0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  csr_perf_unit_if #(.XLEN(32)) bus ();
  csr_perf_unit #(.XLEN(32), .CNT_W(64), .NUM_SCRATCH(4), .NUM_HPM(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .retire_i(retire), .hpm_event_i(ev));
  typedef struct packed {
    logic rn; logic v; logic st; logic ret; logic [3:0] ev;
    logic [11:0] a; logic [2:0] f; logic [31:0] rs; logic [4:0] z;
    logic [31:0] er; logic ei;
  } stim_t;
  typedef struct packed { logic [31:0] rd; logic ill; } exp_t;
  exp_t sb[$];
  function automatic stim_t acc(input logic [11:0] a, input logic [2:0] f, input logic [31:0] rs,
                                input logic [4:0] z, input logic [31:0] er, input logic ei = 1'b0,
                                input logic st = 1'b0, input logic [3:0] e = 4'h0, input logic rn = 1'b1);
    return '{rn: rn, v: 1'b1, st: st, ret: 1'b0, ev: e, a: a, f: f, rs: rs, z: z, er: er, ei: ei};
  endfunction
  function automatic stim_t idle(input logic ret = 1'b0, input logic [3:0] e = 4'h0,
                                 input logic st = 1'b0, input logic rn = 1'b1);
    return '{rn: rn, v: 1'b0, st: st, ret: ret, ev: e, a: 12'h0, f: 3'b0, rs: 32'h0, z: 5'h0,
             er: 32'h0, ei: 1'b0};
  endfunction
  task automatic apply(input stim_t s);
    @(negedge clk);
    rst_n            = s.rn;
    bus.csr_valid    = s.v;
    bus.stall        = s.st;
    retire           = s.ret;
    ev               = s.ev;
    bus.csr_addr     = s.a;
    bus.csr_func3    = s.f;
    bus.csr_rs1_data = s.rs;
    bus.csr_zimm     = s.z;
    sb.push_back('{rd: s.er, ill: s.ei});
  endtask
  task automatic test_reset();
    stim_t t[$];
    exp_t e;
    t.push_back(idle(1'b0, 4'h0, 1'b0, 1'b0));
    t.push_back(acc(12'h340, RSI, 32'h0, 5'h0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0));
    t.push_back(acc(12'hB00, RSI, 32'h0, 5'h0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0));
    for (int i = 0; i < 10; i++) t.push_back(idle());
    t.push_back(acc(12'hB00, RSI, 32'h0, 5'h0, 32'd10));
    t.push_back(acc(12'hB80, RSI, 32'h0, 5'h0, 32'd0));
    foreach (t[i]) begin
      apply(t[i]); #2; e = sb.pop_front(); checks++;
      if (bus.csr_rdata !== e.rd || bus.csr_illegal !== e.ill) begin
        errors++; $display("FAIL reset[%0d] rdata=%h ill=%b required %h %b", i, bus.csr_rdata, bus.csr_illegal, e.rd, e.ill);
      end
    end
  endtask
  task automatic test_carry();
    stim_t t[$];
    exp_t e;
    t.push_back(acc(12'hB00, RW, 32'hFFFF_FFFF, 5'd1, 32'd12));
    t.push_back(acc(12'hB80, RW, 32'h0, 5'd1, 32'd0));
    t.push_back(idle());
    t.push_back(acc(12'hB80, RSI, 32'h0, 5'h0, 32'd1));
    t.push_back(acc(12'hB00, RSI, 32'h0, 5'h0, 32'd1));
    foreach (t[i]) begin
      apply(t[i]); #2; e = sb.pop_front(); checks++;
      if (bus.csr_rdata !== e.rd || bus.csr_illegal !== e.ill) begin
        errors++; $display("FAIL carry[%0d] rdata=%h ill=%b required %h %b", i, bus.csr_rdata, bus.csr_illegal, e.rd, e.ill);
      end
    end
  endtask
  task automatic test_illegal();
    stim_t t[$];
    exp_t e;
    t.push_back(acc(12'hC00, RW, 32'h1234_5678, 5'd1, 32'h0, 1'b1));
    t.push_back(acc(12'hC00, RS, 32'hFFFF_FFFF, 5'd0, 32'd3));
    t.push_back(acc(12'hC80, RSI, 32'h0, 5'h0, 32'd1));
    t.push_back(acc(12'h340, 3'b000, 32'h0, 5'd1, 32'h0, 1'b1));
    t.push_back(acc(12'h340, 3'b100, 32'h0, 5'd1, 32'h0, 1'b1));
    t.push_back(acc(12'hB01, RSI, 32'h0, 5'h0, 32'h0, 1'b1));
    t.push_back(acc(12'h7C4, RSI, 32'h0, 5'h0, 32'h0, 1'b1));
    t.push_back(acc(12'hB07, RSI, 32'h0, 5'h0, 32'h0, 1'b1));
    t.push_back(acc(12'hC80, RSI, 32'h0, 5'd1, 32'h0, 1'b1));
    t.push_back(acc(12'hC02, RCI, 32'h0, 5'h0, 32'h0));
    t.push_back(acc(12'hC00, RSI, 32'h0, 5'h0, 32'd12));
    t.push_back(acc(12'hB06, RSI, 32'h0, 5'h0, 32'h0));
    foreach (t[i]) begin
      apply(t[i]); #2; e = sb.pop_front(); checks++;
      if (bus.csr_rdata !== e.rd || bus.csr_illegal !== e.ill) begin
        errors++; $display("FAIL illegal[%0d] rdata=%h ill=%b required %h %b", i, bus.csr_rdata, bus.csr_illegal, e.rd, e.ill);
      end
    end
  endtask
  task automatic test_mscratch();
    stim_t t[$];
    exp_t e;
    t.push_back(acc(12'h340, RW, 32'hDEAD_BEEF, 5'd5, 32'h0));
    t.push_back(acc(12'h340, RSI, 32'h0, 5'h0, 32'hDEAD_BEEF));
    t.push_back(acc(12'h340, RS, 32'hFFFF_FFFF, 5'h0, 32'hDEAD_BEEF));
    t.push_back(acc(12'h340, RC, 32'h0000_BEEF, 5'd3, 32'hDEAD_BEEF));
    t.push_back(acc(12'h340, RSI, 32'h0, 5'h0, 32'hDEAD_0000));
    t.push_back(acc(12'h340, RSI, 32'h0, 5'h0F, 32'hDEAD_0000));
    t.push_back(acc(12'h340, RCI, 32'h0, 5'h0, 32'hDEAD_000F));
    foreach (t[i]) begin
      apply(t[i]); #2; e = sb.pop_front(); checks++;
      if (bus.csr_rdata !== e.rd || bus.csr_illegal !== e.ill) begin
        errors++; $display("FAIL mscratch[%0d] rdata=%h ill=%b required %h %b", i, bus.csr_rdata, bus.csr_illegal, e.rd, e.ill);
      end
    end
  endtask
  task automatic test_back_to_back();
    stim_t t[$];
    exp_t e;
    t.push_back(acc(12'h7C0, RW, 32'hA0, 5'd1, 32'h0));
    t.push_back(acc(12'h7C3, RW, 32'hA3, 5'd1, 32'h0));
    t.push_back(acc(12'h7C0, RSI, 32'h0, 5'h0, 32'hA0));
    t.push_back(acc(12'h7C3, RWI, 32'h0, 5'h1F, 32'hA3));
    t.push_back(acc(12'h7C3, RSI, 32'h0, 5'h0, 32'h1F));
    t.push_back(acc(12'h7C1, RSI, 32'h0, 5'h0, 32'h0));
    t.push_back(acc(12'h7C2, RS, 32'hF0, 5'd7, 32'h0));
    t.push_back(acc(12'h7C2, RC, 32'h30, 5'd7, 32'hF0));
    t.push_back(acc(12'h7C2, RSI, 32'h0, 5'h0, 32'hC0));
    foreach (t[i]) begin
      apply(t[i]); #2; e = sb.pop_front(); checks++;
      if (bus.csr_rdata !== e.rd || bus.csr_illegal !== e.ill) begin
        errors++; $display("FAIL b2b[%0d] rdata=%h ill=%b required %h %b", i, bus.csr_rdata, bus.csr_illegal, e.rd, e.ill);
      end
    end
  endtask
  task automatic test_inhibit();
    stim_t t[$];
    exp_t e;
    t.push_back(acc(12'h320, RW, 32'hFFFF_FFFF, 5'd1, 32'h0));
    t.push_back(acc(12'h320, RSI, 32'h0, 5'h0, INH_ALL));
    t.push_back(acc(12'h320, RWI, 32'h0, 5'd4, INH_ALL));
    for (int i = 0; i < 5; i++) t.push_back(idle(1'b1));
    t.push_back(acc(12'hB02, RSI, 32'h0, 5'h0, 32'd0));
    t.push_back(acc(12'h320, RCI, 32'h0, 5'd4, 32'h4));
    for (int i = 0; i < 3; i++) t.push_back(idle(1'b1));
    t.push_back(acc(12'hB02, RSI, 32'h0, 5'h0, 32'd3));
    t.push_back(acc(12'hC82, RSI, 32'h0, 5'h0, 32'd0));
    foreach (t[i]) begin
      apply(t[i]); #2; e = sb.pop_front(); checks++;
      if (bus.csr_rdata !== e.rd || bus.csr_illegal !== e.ill) begin
        errors++; $display("FAIL inhibit[%0d] rdata=%h ill=%b required %h %b", i, bus.csr_rdata, bus.csr_illegal, e.rd, e.ill);
      end
    end
  endtask
  task automatic test_hpm_stall();
    stim_t t[$];
    exp_t e;
    t.push_back(acc(12'h340, RW, 32'h55, 5'd1, 32'hDEAD_000F, 1'b0, 1'b1, 4'h2));
    t.push_back(acc(12'h340, RW, 32'h55, 5'd1, 32'hDEAD_000F, 1'b0, 1'b1, 4'h2));
    t.push_back(acc(12'h340, RW, 32'h55, 5'd1, 32'hDEAD_000F, 1'b0, 1'b0, 4'h2));
    t.push_back(idle(1'b0, 4'h2, 1'b1));
    t.push_back(idle(1'b0, 4'h2, 1'b0));
    t.push_back(idle(1'b0, 4'h2, 1'b1));
    t.push_back(idle(1'b0, 4'h2, 1'b0));
    t.push_back(acc(12'h340, RSI, 32'h0, 5'h0, 32'h55));
    t.push_back(acc(12'hB04, RSI, 32'h0, 5'h0, HPM7));
    t.push_back(acc(12'hB03, RSI, 32'h0, 5'h0, 32'h0));
    t.push_back(acc(12'hC84, RSI, 32'h0, 5'h0, 32'h0));
    t.push_back(acc(12'hB04, RW, 32'h10, 5'd1, HPM7, 1'b0, 1'b0, 4'h2));
    t.push_back(acc(12'hB04, RSI, 32'h0, 5'h0, HPM10));
    t.push_back(acc(12'hB84, RSI, 32'h0, 5'h0, 32'h0));
    foreach (t[i]) begin
      apply(t[i]); #2; e = sb.pop_front(); checks++;
      if (bus.csr_rdata !== e.rd || bus.csr_illegal !== e.ill) begin
        errors++; $display("FAIL hpm_stall[%0d] rdata=%h ill=%b required %h %b", i, bus.csr_rdata, bus.csr_illegal, e.rd, e.ill);
      end
    end
  endtask
  task automatic test_async_reset();
    stim_t t[$];
    exp_t e;
    t.push_back(acc(12'h340, RW, 32'h1111, 5'd1, 32'h55));
    t.push_back(acc(12'h340, RSI, 32'h0, 5'h0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0));
    t.push_back(acc(12'hB00, RSI, 32'h0, 5'h0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0));
    t.push_back(acc(12'h340, RSI, 32'h0, 5'h0, 32'h0));
    t.push_back(acc(12'hB00, RSI, 32'h0, 5'h0, 32'd1));
    t.push_back(acc(12'h320, RWI, 32'h0, 5'd1, 32'h0));
    t.push_back(idle());
    t.push_back(acc(12'hB00, RSI, 32'h0, 5'h0, 32'd3));
    t.push_back(acc(12'hB00, RSI, 32'h0, 5'h0, 32'd3));
    t.push_back(acc(12'h320, RWI, 32'h0, 5'd0, 32'h1));
    t.push_back(acc(12'hB00, RSI, 32'h0, 5'h0, 32'd3));
    t.push_back(acc(12'hB00, RSI, 32'h0, 5'h0, 32'd4));
    foreach (t[i]) begin
      apply(t[i]); #2; e = sb.pop_front(); checks++;
      if (bus.csr_rdata !== e.rd || bus.csr_illegal !== e.ill) begin
        errors++; $display("FAIL async_reset[%0d] rdata=%h ill=%b required %h %b", i, bus.csr_rdata, bus.csr_illegal, e.rd, e.ill);
      end
      if (i == 0) rst_n = 1'b0;
    end
  endtask
  initial begin
    test_reset();
    test_carry();
    test_illegal();
    test_mscratch();
    test_back_to_back();
    test_inhibit();
    test_hpm_stall();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/csr_perf_unit.md
# csr_perf_unit

Parametrised control-and-status register unit for the pipelined RV32I core, sitting in EX beside the ALU and feeding the EX result mux. Generalises the single-function CSR file with configurable data width, scratch-register count and counter width, and adds machine cycle/instret counters, event-driven hardware performance counters (for example cache hit and miss strobes), a count-inhibit register and illegal-access detection. Reads are combinational in EX; all writes and counter updates are registered.

## Interface
- XLEN, 32: data width of CSR read/write data.
- CNT_W, 64: counter width; legal range XLEN < CNT_W ≤ 2·XLEN.
- NUM_SCRATCH, 4: custom RW scratch CSRs at 0x7C0..0x7C0+NUM_SCRATCH-1 (1..16).
- NUM_HPM, 4: event counters mhpmcounter3..3+NUM_HPM-1 (1..8).
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- csr_valid  in  1  a CSR instruction is in EX.
- stall  in  1  EX held (bubbleE); suppresses writes.
- csr_addr  in  12  CSR address.
- csr_func3  in  3  instruction funct3.
- csr_rs1_data  in  XLEN  forwarded rs1 value.
- csr_zimm  in  5  rs1 field / zero-extended immediate.
- retire  in  1  one instruction retired this cycle.
- hpm_event  in  NUM_HPM  per-counter event strobes, one increment per high cycle.
- csr_rdata  out  XLEN  old CSR value (combinational).
- csr_illegal  out  1  access is illegal (combinational).

## Operation
- Address map: mcountinhibit 0x320 (bit0 CY, bit2 IR, bit 3+i HPM i; other bits read 0); mscratch 0x340; scratch 0x7C0+k; mcycle 0xB00/0xB80 (h); minstret 0xB02/0xB82; mhpmcounter(3+i) 0xB03+i/0xB83+i; read-only shadows cycle 0xC00/0xC80, instret 0xC02/0xC82, hpmcounter 0xC03+i/0xC83+i.
- High halves return counter bits CNT_W-1:XLEN, zero-extended.
- funct3: 001 RW, 010 RS, 011 RC use csr_rs1_data; 101/110/111 are immediate forms using {0, csr_zimm}. RW writes src; RS writes old|src; RC writes old&~src.
- RS/RC/RSI/RCI with csr_zimm==0 perform no write and are legal on read-only CSRs.
- csr_illegal=1 when csr_valid and: unmapped address, funct3 000 or 100, or a writing access to 0xCxx. Illegal accesses never write; csr_rdata=0.
- Write commit: csr_valid & ~stall & ~csr_illegal & write-enabled.
- Counters: mcycle +1 every cycle unless inhibited; minstret +1 when retire unless inhibited; hpm i +1 when hpm_event[i] unless inhibited. All wrap modulo 2^CNT_W.
- Writing a counter half replaces that half only; that counter does not increment in the same cycle (write wins). The other half is unchanged.

## Timing
- Reset: all counters, scratch, mscratch, mcountinhibit = 0. csr_rdata=0, csr_illegal=0 while csr_valid=0.
- Read latency 0 (same-cycle combinational); returns pre-write value.
- Written value visible to a read one cycle later; counter read in cycle after a write returns the written value (no increment that cycle).
- Counter read returns value before this cycle's increment.
- Low-half carry propagates into high half in the same update (single CNT_W-bit add).
- stall held: no write, counters still count; write commits in the cycle stall drops if csr_valid still high.
- rst_n asserted mid-operation clears all state immediately; pending write lost.

## Configuration
- CSR_HPM_EN defined: NUM_HPM event counters and their mcountinhibit bits implemented.
- Undefined: hpm addresses remain legal, read 0, writes discarded, no counter flops; hpm_event ignored; mcountinhibit bits 3+ read 0.

## Test plan
- Reset, release, idle 10 cycles, read 0xB00 -> 10 (±fixed offset documented by bench), 0xB80 -> 0.
- CSRRW 0x340 with rs1=0xDEADBEEF, next cycle CSRRS 0x340 zimm=0 -> rdata 0xDEADBEEF, no write.
- Write mcycle=0xFFFFFFFF, mcycleh=0; two cycles later read mcycleh -> 1 (carry), mcycle low -> 1.
- CSRRW to 0xC00 -> csr_illegal=1, rdata 0, cycle unchanged; CSRRS 0xC00 zimm=0 -> legal.
- Set mcountinhibit=0x4, pulse retire 5× -> minstret 0; clear, pulse 3× -> 3.
- Pulse hpm_event[1] 7× with stall toggling -> 0xB04 reads 7 (CSR_HPM_EN) or 0 (undefined).
